// File: rtl/retry_pkg.sv
// Shared definitions for the in-order retry pair.
// No ports. Provides the default ID width and a helper sizing the per-ID
// storage (data memory and retry FIFO both hold one entry per ID value).
package retry_pkg;

  localparam int unsigned DefaultIdSize = 3;

  // Number of distinct IDs, and hence storage entries, for a given ID width.
  function automatic int unsigned id_entries(int unsigned id_size);
    return 32'd1 << id_size;
  endfunction

endpackage

// File: rtl/retry_id_fifo.sv
// Synchronous-reset FIFO of element IDs waiting to be re-issued.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   push_i, data_i  enqueue an ID (ignored when full)
//   pop_i, data_o   dequeue the head ID (ignored when empty); data_o is the head
//   full_o, empty_o occupancy flags
//   count_o         number of queued IDs (0 .. 2**Width)
module retry_id_fifo
  import retry_pkg::*;
#(
  parameter int unsigned Width = DefaultIdSize
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width:0]   count_o
);

  localparam int unsigned Depth = id_entries(Width);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] head_q, tail_q;
  logic [Width:0]   count_q;
  logic             do_push, do_pop;

  // Depth is a power of two, so the count MSB is set exactly when full.
  assign full_o  = count_q[Width];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[head_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Pointers are exactly log2(Depth) wide and wrap on their own.
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/retry_inorder_start.sv
// Upstream half of the in-order retry pair.
// Tags each issued element with a sequential ID, keeps a copy of its data by
// ID, and re-issues failed elements (with fresh IDs, in original order) ahead
// of any new input.
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   data_i, valid_i, ready_o           new elements from upstream
//   data_o, id_o, valid_o, ready_i     elements into the operation
//   retry_id_i, retry_valid_i,
//   retry_ready_o                      retry requests from the end stage
//   retry_lock_i                       end stage in retry mode: no new issue
//   retry_id_feedback_o                ID the latest failed element will get
module retry_inorder_start
  import retry_pkg::*;
#(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = DefaultIdSize
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic [IDSize-1:0] retry_id_i,
  input  logic              retry_valid_i,
  output logic              retry_ready_o,
  input  logic              retry_lock_i,
  output logic [IDSize-1:0] retry_id_feedback_o
);

  localparam int unsigned Depth = id_entries(IDSize);

  logic [IDSize-1:0] next_id_q;
  DataType           mem_q [Depth];

  logic              fifo_full, fifo_empty;
  logic [IDSize-1:0] head_id;
  logic [IDSize:0]   fifo_count;
  logic              replay, issue;

  retry_id_fifo #(
    .Width (IDSize)
  ) u_retry_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (retry_valid_i),
    .data_i  (retry_id_i),
    .pop_i   (issue & replay),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign replay = ~fifo_empty;

  // Queued retries always win over new input; the lock only stalls new input.
  always_comb begin
    data_o  = data_i;
    valid_o = valid_i & ~retry_lock_i;
    ready_o = ready_i & ~retry_lock_i;
    if (replay) begin
      data_o  = mem_q[head_id];
      valid_o = 1'b1;
      ready_o = 1'b0;
    end
  end

  assign id_o  = next_id_q;
  assign issue = valid_o & ready_i;

  // Full is taken from the registered count: a same-cycle pop does not free space.
  assign retry_ready_o = ~fifo_full;

  // A request pushed now queues behind fifo_count entries, each of which takes
  // one ID when re-issued. Truncation gives the modulo-2**IDSize wrap.
  assign retry_id_feedback_o = IDSize'(next_id_q + fifo_count);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      next_id_q <= '0;
    end else if (issue) begin
      next_id_q <= next_id_q + 1'b1;
    end
  end

  // Storage content is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (issue) mem_q[next_id_q] <= data_o;
  end

endmodule
